// File: rtl/nibble_serial_logic_pkg.sv
// Shared definitions for the nibble-serial logic unit: op encoding and FSM states.
// Imported by the top level and by the slice ALU.
package nibble_serial_logic_pkg;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_serial_logic_four_bit_logic.sv
// Combinational bitwise op unit for one slice of the operands.
// Applies AND / OR / XOR / NOR to a SLICE-wide pair of inputs.
module four_bit_logic
  import nibble_serial_logic_pkg::*;
#(
  parameter int SLICE = 4
) (
  input  logic [1:0]       op,
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  output logic [SLICE-1:0] y
);

  always_comb begin
    // NOTE: default assignment before the case keeps this purely combinational (no inferred latch).
    y = '0;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NOR:  y = ~(a | b);
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/nibble_serial_logic.sv
// Bitwise logic unit that processes WIDTH-bit operands one SLICE per cycle,
// with valid/ready handshakes on both the request and the result side.
module nibble_serial_logic
  import nibble_serial_logic_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             busy
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(NSLICE - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [1:0]       op_reg;
  logic [WIDTH-1:0] y_reg;

  logic [SLICE-1:0] a_slice;
  logic [SLICE-1:0] b_slice;
  logic [SLICE-1:0] y_slice;

  // The single op unit is time-shared: the counter selects which slice it sees.
  assign a_slice = a_reg[cnt*SLICE +: SLICE];
  assign b_slice = b_reg[cnt*SLICE +: SLICE];

  four_bit_logic #(
    .SLICE (SLICE)
  ) u_alu (
    .op (op_reg),
    .a  (a_slice),
    .b  (b_slice),
    .y  (y_slice)
  );

  // NOTE: all state, including the handshake flags, uses non-blocking assignments.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      op_reg    <= OP_AND;
      y_reg     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            a_reg    <= a;
            b_reg    <= b;
            op_reg   <= op;
            cnt      <= '0;
            y_reg    <= '0;
            state    <= ST_RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        ST_RUN: begin
          y_reg[cnt*SLICE +: SLICE] <= y_slice;
          if (cnt == LAST_SLICE) begin
            cnt       <= '0;
            state     <= ST_DONE;
            out_valid <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: begin
          // Result and flags stay frozen until the consumer takes them.
          if (out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  assign y    = y_reg;
  assign zero = ~|y_reg;

endmodule

// File: tb/tb_nibble_serial_logic.sv
// Randomized self-checking bench for nibble_serial_logic: a word-level model
// is compared against the DUT every cycle, plus directed literal scenarios.
module tb_nibble_serial_logic;

  localparam int WIDTH  = 32;
  localparam int SLICE  = 4;
  localparam int NSLICE = WIDTH / SLICE;

  logic             clk = 1'b0;
  logic             reset_n = 1'b1;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic [1:0]       op = 2'b00;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] y;
  logic             zero;
  logic             busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  nibble_serial_logic #(
    .WIDTH (WIDTH),
    .SLICE (SLICE)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .zero      (zero),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] ref_op(input logic [1:0] o, input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] z);
    case (o)
      2'b00:   return x & z;
      2'b01:   return x | z;
      2'b10:   return x ^ z;
      default: return ~(x | z);
    endcase
  endfunction

  // Word-level reference: the whole result is known at the handshake, and y
  // reveals one more low slice of it per RUN cycle.
  typedef enum {M_IDLE, M_BUSY, M_HOLD} mphase_t;
  mphase_t          m_phase  = M_IDLE;
  int               m_slices = NSLICE;
  logic [WIDTH-1:0] m_result = '0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_phase  <= M_IDLE;
      m_slices <= NSLICE;
      m_result <= '0;
    end else begin
      case (m_phase)
        M_IDLE: if (in_valid) begin
          m_result <= ref_op(op, a, b);
          m_slices <= 0;
          m_phase  <= M_BUSY;
        end
        M_BUSY: begin
          m_slices <= m_slices + 1;
          if (m_slices + 1 == NSLICE) m_phase <= M_HOLD;
        end
        M_HOLD: if (out_ready) m_phase <= M_IDLE;
        default: m_phase <= M_IDLE;
      endcase
    end
  end

  function automatic logic [WIDTH-1:0] model_y();
    logic [63:0] mask;
    if (m_slices >= NSLICE) return m_result;
    mask = (64'd1 << (m_slices * SLICE)) - 64'd1;
    return m_result & mask[WIDTH-1:0];
  endfunction

  always @(negedge clk) begin
    logic [WIDTH-1:0] exp_y;
    exp_y = model_y();
    check("cycle in_ready", in_ready, m_phase == M_IDLE);
    check("cycle out_valid", out_valid, m_phase == M_HOLD);
    check("cycle busy", busy, m_phase != M_IDLE);
    check("cycle y", y, exp_y);
    if (m_phase == M_HOLD || !reset_n) check("cycle zero", zero, exp_y == '0);
  end

  // Presents the current inputs until accepted; returns the cycle of the accepting edge.
  task automatic wait_hs(output int hs_cyc);
    bit seen;
    seen = 1'b0;
    hs_cyc = -1;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      seen = in_ready;
      @(posedge clk);
      if (seen) hs_cyc = cyc;
    end
    #1;
    check("handshake accepted", seen, 1'b1);
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 4 * NSLICE) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic do_req(input string tag, input logic [1:0] o, input logic [WIDTH-1:0] x,
                        input logic [WIDTH-1:0] z, input logic [WIDTH-1:0] exp,
                        input int hold, input bit scramble);
    int lat;
    int hs;
    a = x; b = z; op = o;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    wait_hs(hs);
    in_valid = 1'b0;
    if (scramble) begin
      a  = ~a;
      b  = $urandom;
      op = op ^ 2'b11;
    end
    wait_out(lat);
    check({tag, " latency"}, lat, NSLICE);
    check({tag, " y"}, y, exp);
    check({tag, " zero"}, zero, exp == '0);
    if (hold > 0) begin
      in_valid = 1'b1;
      a  = $urandom;
      op = 2'($urandom);
      for (int i = 0; i < hold; i++) begin
        @(posedge clk);
        #1;
        check({tag, " held y"}, y, exp);
        check({tag, " held out_valid"}, out_valid, 1'b1);
        check({tag, " held in_ready"}, in_ready, 1'b0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    check({tag, " released"}, out_valid, 1'b0);
    check({tag, " ready again"}, in_ready, 1'b1);
    out_ready = 1'($urandom);
  endtask

  initial begin
    int hs1;
    int hs2;
    int lat;
    int stale;
    logic [1:0]       ro;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;

    #1 reset_n = 1'b0;
    #1;
    check("reset in_ready", in_ready, 1'b1);
    check("reset out_valid", out_valid, 1'b0);
    check("reset busy", busy, 1'b0);
    check("reset y", y, 32'h0);
    check("reset zero", zero, 1'b1);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    do_req("and", 2'b00, 32'hFFFF0000, 32'h0F0F0F0F, 32'h0F0F0000, 0, 1'b0);
    do_req("nor", 2'b11, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 0, 1'b0);
    do_req("xor", 2'b10, 32'hDEADBEEF, 32'hDEADBEEF, 32'h00000000, 0, 1'b0);
    do_req("backpressure", 2'b01, 32'h0000F000, 32'h00000001, 32'h0000F001, 5, 1'b0);
    do_req("latched", 2'b10, 32'h12345678, 32'hFFFF0000, 32'hEDCB5678, 0, 1'b1);

    // Abort in the middle of RUN, after slices 0..2 have been written.
    a = 32'hA5A5A5A5; b = 32'h0; op = 2'b01;
    in_valid = 1'b1; out_ready = 1'b1;
    wait_hs(hs1);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("abort in_ready", in_ready, 1'b1);
    check("abort out_valid", out_valid, 1'b0);
    check("abort y", y, 32'h0);
    check("abort busy", busy, 1'b0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    stale = 0;
    repeat (NSLICE + 2) begin
      @(posedge clk);
      #1;
      if (out_valid) stale++;
    end
    check("abort no stale result", stale, 0);
    do_req("after abort", 2'b00, 32'hCAFEBABE, 32'hFFFF0000, 32'hCAFE0000, 0, 1'b0);

    // Back-to-back with in_valid held high throughout.
    a = 32'hFF00FF00; b = 32'h0F0F0F0F; op = 2'b10;
    in_valid = 1'b1; out_ready = 1'b1;
    wait_hs(hs1);
    a = 32'h0000FFFF; b = 32'h00FF0000; op = 2'b11;
    wait_out(lat);
    check("b2b first y", y, 32'hF00FF00F);
    wait_hs(hs2);
    in_valid = 1'b0;
    check("b2b second accept cycle", hs2 - hs1, NSLICE + 2);
    wait_out(lat);
    check("b2b second latency", lat, NSLICE);
    check("b2b second y", y, 32'hFF000000);
    @(posedge clk);
    #1;
    check("b2b released", out_valid, 1'b0);

    for (int n = 0; n < 40; n++) begin
      int gap;
      ro = 2'($urandom);
      ra = $urandom;
      rb = (n % 7 == 0) ? ra : $urandom;
      do_req("random", ro, ra, rb, ref_op(ro, ra, rb), $urandom_range(0, 3),
             1'($urandom_range(0, 1)));
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (checks %0d errors %0d)", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/nibble_serial_logic.md
NIBBLE_SERIAL_LOGIC -- requirements
Module: nibble_serial_logic

Interface
REQ-001 Parameter WIDTH, default 32, operand and result width; SHALL be a multiple of SLICE.
REQ-002 Parameter SLICE, default 4, bits processed per cycle; NSLICE = WIDTH/SLICE (8 by default).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  reset, asynchronous and active-low.
REQ-005 in_valid  input  1  request present on a, b, op.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 op  input  2  operation: 00 AND, 01 OR, 10 XOR, 11 NOR.
REQ-010 out_valid  output  1  result on y and zero is valid.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 y  output  WIDTH  result.
REQ-013 zero  output  1  high when y == 0; meaningful only while out_valid is high.
REQ-014 busy  output  1  high in RUN and DONE.

Function
REQ-015 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-016 In IDLE, in_ready SHALL be 1; in RUN and DONE it SHALL be 0.
REQ-017 On a handshake (in_valid && in_ready) the block SHALL latch a, b and op, clear the slice counter to 0, clear y_reg, and go to RUN. Later input changes SHALL be ignored.
REQ-018 In RUN, each cycle SHALL compute slice k = counter: y_reg[k*SLICE +: SLICE] = op(a_reg slice, b_reg slice), then increment the counter.
REQ-019 When the counter equals NSLICE-1, the cycle SHALL write the last slice and transition to DONE.
REQ-020 Latency: for a handshake at edge N, out_valid SHALL go high after edge N+NSLICE (N+8 by default).
REQ-021 In DONE, out_valid SHALL be 1, and y and zero SHALL be held stable until out_valid && out_ready.
REQ-022 On out_valid && out_ready the block SHALL return to IDLE, with out_valid low from the next cycle.
REQ-023 There is no overlap: a new request SHALL be accepted no earlier than the cycle after the result handshake.
REQ-024 out_ready asserted outside DONE SHALL have no effect; in_valid outside IDLE SHALL have no effect.
REQ-025 zero SHALL be derived from the complete y_reg and driven combinationally from registered state.

Reset
REQ-026 When reset_n is low, the state SHALL be IDLE, and the counter, a_reg, b_reg, op_reg and y_reg SHALL be 0.
REQ-027 Output values during reset: in_ready=1, out_valid=0, busy=0, y=0. zero reads 1 but is not valid.
REQ-028 Reset asserted mid-operation (RUN or DONE) SHALL abort the request immediately; no result SHALL be delivered after release.

Structure
REQ-029 A shared package SHALL hold the op encoding constants (OP_AND, OP_OR, OP_XOR, OP_NOR) and the state enum, for reuse by the ALU.
REQ-030 A single sub-module, four_bit_logic (SLICE-wide combinational op unit), SHALL be instantiated once and muxed by the counter.

Verification
REQ-031 op=00, a=0xFFFF0000, b=0x0F0F0F0F, out_ready=1 -> out_valid 8 cycles after the handshake, y=0x0F0F0000, zero=0.
REQ-032 op=11, a=0, b=0 -> y=0xFFFFFFFF, zero=0. Then op=10, a=b=0xDEADBEEF -> y=0, zero=1.
REQ-033 Backpressure: op=01, a=0x0000F000, b=0x00000001, out_ready low for 5 cycles in DONE -> y=0x0000F001 held, in_ready=0, in_valid ignored; completes on the out_ready cycle.
REQ-034 Input change after the handshake: change a and op during RUN -> result reflects the latched values only.
REQ-035 Reset mid-RUN at slice 3 -> immediately in_ready=1, out_valid=0, y=0. A fresh request afterwards completes with the correct value and latency.
REQ-036 Back-to-back: in_valid held high with out_ready=1 -> second request accepted in the cycle after the first result handshake; each result is correct.
